relay_ripple_adder: RTL and testbench

- Parametrised, clocked successor to the 1-bit relay adder cell. Adds two WIDTH-bit operands one bit at a time, from LSB to MSB.
- Each bit's carry takes RELAY_DELAY clock cycles to settle, which models relay propagation timing.
- Sits in the arithmetic-logic unit between the B/C register outputs and the ALU result/flag path.
- Valid/ready handshakes on both the request side and the result side.

---
 rtl/relay_ripple_adder_pkg.sv | 17 +
 rtl/relay_ripple_adder_if.sv | 30 +++
 rtl/relay_ripple_adder_full_adder_cell.sv | 11 +
 rtl/relay_ripple_adder.sv | 103 ++++++++++
 tb/tb_relay_ripple_adder.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/relay_ripple_adder_pkg.sv
// Shared types for the relay ALU: operation codes and ripple-adder FSM states.
package relay_alu_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'b00,
    ADC  = 2'b01,
    INC  = 2'b10,
    RSVD = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    RIPPLE,
    DONE
  } adder_state_t;

endpackage

// File: rtl/relay_ripple_adder_if.sv
// Request/result handshake bus between the ALU sequencer and the relay ripple adder.
interface relay_ripple_adder_if
  import relay_alu_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  op_t              op;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] c_in;
  logic             carry_in;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             zero;
  logic             sign;
  logic             busy;

  modport master (
    output start_valid, op, b_in, c_in, carry_in, done_ready,
    input  start_ready, done_valid, sum, carry_out, zero, sign, busy
  );

  modport slave (
    input  start_valid, op, b_in, c_in, carry_in, done_ready,
    output start_ready, done_valid, sum, carry_out, zero, sign, busy
  );
endinterface

// File: rtl/relay_ripple_adder_full_adder_cell.sv
// Combinational 1-bit full adder, shared across all bit positions of the ripple adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/relay_ripple_adder.sv
// Bit-serial relay adder: one full-adder cell resolves one bit every RELAY_DELAY cycles, LSB first.
module relay_ripple_adder
  import relay_alu_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int RELAY_DELAY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  relay_ripple_adder_if.slave  bus
);
  localparam int IDX_W = $clog2(WIDTH + 1);
  localparam int CNT_W = (RELAY_DELAY > 1) ? $clog2(RELAY_DELAY) : 1;

  adder_state_t     state, state_next;
  logic [WIDTH-1:0] a_sh, c_sh, bit_mask, work_sum, sum_next;
  logic [WIDTH-1:0] sum_q;
  logic             carry, carry_q, zero_q, sign_q;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum, fa_carry, resolve, last;

  // Operands shift right so the cell always sees bit[idx] at position 0;
  // the one-hot mask marks where the resolved bit lands in the working sum.
  full_adder_cell u_cell (
    .a    (a_sh[0]),
    .b    (c_sh[0]),
    .cin  (carry),
    .s    (fa_sum),
    .cout (fa_carry)
  );

  assign resolve  = (state == RIPPLE) && (cnt == CNT_W'(RELAY_DELAY - 1));
  assign last     = resolve && (idx == IDX_W'(WIDTH - 1));
  assign sum_next = work_sum | (fa_sum ? bit_mask : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start_valid) state_next = RIPPLE;
      RIPPLE:  if (last)            state_next = DONE;
      DONE:    if (bus.done_ready)  state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      c_sh     <= '0;
      bit_mask <= '0;
      work_sum <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      cnt      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      if (state == IDLE && bus.start_valid) begin
        a_sh     <= bus.b_in;
        c_sh     <= (bus.op == INC) ? '0 : bus.c_in;
        carry    <= (bus.op == ADC) ? bus.carry_in : (bus.op == INC);
        bit_mask <= WIDTH'(1);
        work_sum <= '0;
        idx      <= '0;
        cnt      <= '0;
      end else if (state == RIPPLE) begin
        if (resolve) begin
          a_sh     <= a_sh >> 1;
          c_sh     <= c_sh >> 1;
          bit_mask <= bit_mask << 1;
          work_sum <= sum_next;
          carry    <= fa_carry;
          idx      <= idx + 1'b1;
          cnt      <= '0;
          if (last) begin
            sum_q   <= sum_next;
            carry_q <= fa_carry;
            zero_q  <= (sum_next == '0);
            sign_q  <= sum_next[WIDTH-1];
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.start_ready = (state == IDLE);
  assign bus.done_valid  = (state == DONE);
  assign bus.busy        = (state != IDLE);
  assign bus.sum         = sum_q;
  assign bus.carry_out   = carry_q;
  assign bus.zero        = zero_q;
  assign bus.sign        = sign_q;
endmodule

// File: tb/tb_relay_ripple_adder.sv
// Bench for relay_ripple_adder: directed and random operations on RELAY_DELAY=2 and =1 instances.
module tb_relay_ripple_adder;
  import relay_alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  logic       sv[2], ci[2], dr[2];
  logic [1:0] opv[2];
  logic [7:0] bv[2], cv[2];
  logic       sr[2], dv[2], co[2], zr[2], sg[2], bz[2];
  logic [7:0] sm[2];

  relay_ripple_adder_if #(.WIDTH(8)) bus[2] ();

  for (genvar g = 0; g < 2; g++) begin : g_conn
    assign bus[g].start_valid = sv[g];
    assign bus[g].op          = op_t'(opv[g]);
    assign bus[g].b_in        = bv[g];
    assign bus[g].c_in        = cv[g];
    assign bus[g].carry_in    = ci[g];
    assign bus[g].done_ready  = dr[g];
    assign sr[g] = bus[g].start_ready;
    assign dv[g] = bus[g].done_valid;
    assign sm[g] = bus[g].sum;
    assign co[g] = bus[g].carry_out;
    assign zr[g] = bus[g].zero;
    assign sg[g] = bus[g].sign;
    assign bz[g] = bus[g].busy;
  end

  relay_ripple_adder #(.WIDTH(8), .RELAY_DELAY(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus[0])
  );

  relay_ripple_adder #(.WIDTH(8), .RELAY_DELAY(1)) u_dut_fast (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {carry, sum} of the operation as plain 9-bit arithmetic.
  function automatic logic [8:0] ref_result(input logic [1:0] op, input logic [7:0] b,
                                            input logic [7:0] c, input logic cin);
    case (op)
      2'b01:   return {1'b0, b} + {1'b0, c} + {8'd0, cin};
      2'b10:   return {1'b0, b} + 9'd1;
      default: return {1'b0, b} + {1'b0, c};
    endcase
  endfunction

  task automatic check_result(input int s, input logic [8:0] exp);
    check_eq("sum", sm[s], exp[7:0]);
    check_eq("carry_out", co[s], exp[8]);
    check_eq("zero", zr[s], exp[7:0] == 8'd0);
    check_eq("sign", sg[s], exp[7]);
  endtask

  task automatic run_op(input int s, input logic [1:0] op, input logic [7:0] b, input logic [7:0] c,
                        input logic cin, input int lat, input bit hold);
    logic [8:0] exp;
    int n;
    exp = ref_result(op, b, c, cin);
    @(negedge clk);
    check_eq("start_ready_idle", sr[s], 1'b1);
    sv[s] = 1'b1; opv[s] = op; bv[s] = b; cv[s] = c; ci[s] = cin;
    @(posedge clk); #1;
    sv[s] = 1'b0; bv[s] = 8'($urandom); cv[s] = 8'($urandom); ci[s] = 1'($urandom);
    check_eq("busy_after_accept", bz[s], 1'b1);
    n = 0;
    while (!dv[s] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("latency", n, lat);
    check_result(s, exp);
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        sv[s] = 1'b1; opv[s] = 2'($urandom); bv[s] = 8'($urandom); cv[s] = 8'($urandom);
        @(posedge clk); #1;
        check_eq("hold_done_valid", dv[s], 1'b1);
        check_eq("hold_start_ready", sr[s], 1'b0);
        check_eq("hold_sum", sm[s], exp[7:0]);
        check_eq("hold_carry", co[s], exp[8]);
      end
      @(negedge clk);
      sv[s] = 1'b0;
    end
    @(negedge clk);
    dr[s] = 1'b1;
    @(posedge clk); #1;
    dr[s] = 1'b0;
    check_eq("done_valid_release", dv[s], 1'b0);
    check_eq("start_ready_release", sr[s], 1'b1);
    check_eq("busy_release", bz[s], 1'b0);
    check_eq("sum_held_idle", sm[s], exp[7:0]);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sv[i] = 1'b0; ci[i] = 1'b0; dr[i] = 1'b0; opv[i] = 2'b00; bv[i] = '0; cv[i] = '0;
    end
    repeat (2) @(negedge clk);
    check_eq("rst_sum", sm[0], 8'h00);
    check_eq("rst_done_valid", dv[0], 1'b0);
    check_eq("rst_busy", bz[0], 1'b0);
    check_eq("rst_flags", {co[0], zr[0], sg[0]}, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_start_ready", sr[0], 1'b1);

    run_op(0, 2'b00, 8'h00, 8'h01, 1'b0, 16, 1'b0);
    run_op(0, 2'b00, 8'hFF, 8'h01, 1'b1, 16, 1'b0);
    run_op(0, 2'b01, 8'h7F, 8'h00, 1'b1, 16, 1'b0);
    run_op(0, 2'b10, 8'hFF, 8'h55, 1'b0, 16, 1'b0);
    run_op(0, 2'b11, 8'hF0, 8'h0F, 1'b1, 16, 1'b0);
    for (int i = 0; i < 20; i++)
      run_op(0, 2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 16, 1'b0);
    run_op(0, 2'b00, 8'h10, 8'h20, 1'b0, 16, 1'b1);

    // Reset seven cycles into a ripple: outputs clear at once and nothing completes.
    @(negedge clk);
    sv[0] = 1'b1; opv[0] = 2'b00; bv[0] = 8'hAA; cv[0] = 8'h11;
    @(posedge clk); #1;
    sv[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_sum", sm[0], 8'h00);
    check_eq("midrst_flags", {co[0], zr[0], sg[0]}, 3'b000);
    check_eq("midrst_done_valid", dv[0], 1'b0);
    check_eq("midrst_busy", bz[0], 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (dv[0]) n++;
    end
    check_eq("no_partial_result", n, 0);
    run_op(0, 2'b00, 8'h12, 8'h34, 1'b0, 16, 1'b0);
    check_eq("add_12_34", sm[0], 8'h46);

    run_op(1, 2'b00, 8'h12, 8'h34, 1'b0, 8, 1'b0);
    run_op(1, 2'b10, 8'hFF, 8'h00, 1'b0, 8, 1'b0);
    for (int i = 0; i < 15; i++)
      run_op(1, 2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 8, 1'b0);
    run_op(1, 2'b01, 8'h80, 8'h7F, 1'b1, 8, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
